// File: rtl/commit_trace.sv
// rtl/commit_trace.sv - Commit-trace transmitter: captures retired-instruction records and streams them as 3-word packets.
module commit_trace #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trace_en,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_we,
    input  logic [4:0]  commit_rd,
    input  logic [31:0] commit_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [15:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {W0, W1, W2} state_t;

    state_t           state_q;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [15:0]      drop_q, drop_d;

    logic [31:0]      pc_mem    [DEPTH];
    logic             we_mem    [DEPTH];
    logic [4:0]       rd_mem    [DEPTH];
    logic [31:0]      wdata_mem [DEPTH];
    logic [SEQ_W-1:0] seq_mem   [DEPTH];

    logic [AW:0]   count;
    logic          full, empty;
    logic          capture, handshake, pop, push, drop;
    logic [AW-1:0] wr_idx, rd_idx;

    assign count     = wr_ptr_q - rd_ptr_q;
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign wr_idx    = wr_ptr_q[AW-1:0];
    assign rd_idx    = rd_ptr_q[AW-1:0];

    assign capture   = commit_valid & trace_en;
    assign handshake = out_valid & out_ready;
    assign pop       = handshake & (state_q == W2);
    // When full, the slot being written is the one the W2 pop frees on this same edge.
    assign push      = capture & (~full | pop);
    assign drop      = capture & ~push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        seq_d    = seq_q;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (capture) begin
            seq_d = seq_q + 1'b1;
        end
        if (drop && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_idx]    <= commit_pc;
            we_mem[wr_idx]    <= commit_we;
            rd_mem[wr_idx]    <= commit_rd;
            wdata_mem[wr_idx] <= commit_we ? commit_wdata : 32'h0;
            seq_mem[wr_idx]   <= seq_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= W0;
        end else if (handshake) begin
            case (state_q)
                W0:      state_q <= W1;
                W1:      state_q <= W2;
                default: state_q <= W0;
            endcase
        end
    end

    always_comb begin
        out_data = 32'h0;
        if (!empty) begin
            case (state_q)
                W0:      out_data = pc_mem[rd_idx];
                W1:      out_data = {we_mem[rd_idx], rd_mem[rd_idx], 10'h000, 16'(seq_mem[rd_idx])};
                default: out_data = wdata_mem[rd_idx];
            endcase
        end
    end

    assign out_valid  = ~empty;
    assign out_last   = ~empty & (state_q == W2);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_commit_trace.sv
// tb/tb_commit_trace.sv - Self-checking bench for commit_trace against a queue-based record model.
module tb_commit_trace;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_en = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0;
    logic        commit_we = 1'b0;
    logic [4:0]  commit_rd = '0;
    logic [31:0] commit_wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    commit_trace #(.DEPTH(DEPTH), .SEQ_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_we(commit_we), .commit_rd(commit_rd),
        .commit_wdata(commit_wdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [15:0] seq;
    } rec_t;

    rec_t        mq[$];
    int          m_idx;
    int          m_seq;
    int          m_drops;
    logic [31:0] got[$];

    function automatic logic exp_valid();
        return mq.size() != 0;
    endfunction

    function automatic logic [31:0] exp_data();
        if (mq.size() == 0) return 32'h0;
        case (m_idx)
            0:       return mq[0].pc;
            1:       return {mq[0].we, mq[0].rd, 10'h000, mq[0].seq};
            default: return mq[0].wd;
        endcase
    endfunction

    function automatic logic exp_last();
        return (mq.size() != 0) && (m_idx == 2);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        commit_valid = 1'b0;
        out_ready = 1'b0;
        mq.delete();
        m_idx = 0;
        m_seq = 0;
        m_drops = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one cycle of inputs and advances the model across the rising edge; returns at the next negedge.
    task automatic drive_cycle(input logic cv, input logic en, input logic [31:0] pc, input logic we,
                               input logic [4:0] rd, input logic [31:0] wd, input logic rdy);
        int   sz;
        bit   cap, hs, pop;
        rec_t r;
        commit_valid = cv;
        trace_en = en;
        commit_pc = pc;
        commit_we = we;
        commit_rd = rd;
        commit_wdata = wd;
        out_ready = rdy;
        sz  = mq.size();
        cap = cv && en;
        hs  = (sz > 0) && rdy;
        pop = hs && (m_idx == 2);
        @(posedge clk);
        if (hs) begin
            if (m_idx == 2) begin
                void'(mq.pop_front());
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (cap) begin
            if (sz < DEPTH || pop) begin
                r.pc = pc; r.we = we; r.rd = rd; r.wd = we ? wd : 32'h0; r.seq = 16'(m_seq);
                mq.push_back(r);
            end else if (m_drops < 65535) begin
                m_drops++;
            end
            m_seq = (m_seq + 1) % 65536;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        drive_cycle(1'b0, 1'b1, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
    endtask

    task automatic collect(input int cycles);
        got.delete();
        for (int i = 0; i < cycles; i++) begin
            if (out_valid) got.push_back(out_data);
            idle(1'b1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b0 || out_data !== 32'h0 || drop_count !== 16'h0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d valid=%b data=%h drops=%h last=%b required 0/0/0/0",
                         i, out_valid, out_data, drop_count, out_last);
            end
            idle(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_single_commit();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h00400000; exp_w[1] = 32'hC0000000; exp_w[2] = 32'h0000000A;
        do_reset();
        drive_cycle(1'b1, 1'b1, 32'h00400000, 1'b1, 5'd16, 32'h0000000A, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w[i] || out_last !== (i == 2)) begin
                errors++;
                $display("FAIL single_word%0d valid=%b data=%h last=%b required 1/%h/%b",
                         i, out_valid, out_data, out_last, exp_w[i], i == 2);
            end
            idle(1'b1);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_after valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive_cycle(1'b1, 1'b1, 32'h00400000, 1'b1, 5'd16, 32'h0000000A, 1'b1);
        idle(1'b1);
        drive_cycle(1'b1, 1'b1, 32'h00400004, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_data !== 32'hC0000000 || out_valid !== 1'b1 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d data=%h valid=%b last=%b required C0000000/1/0",
                         i, out_data, out_valid, out_last);
            end
            if (i < 2) idle(1'b0);
        end
        collect(8);
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL bp_count got=%0d words required 5", got.size());
        end else begin
            checks++;
            if (got[0] !== 32'hC0000000 || got[1] !== 32'h0000000A || got[2] !== 32'h00400004 ||
                got[3] !== 32'h00000001 || got[4] !== 32'h00000000) begin
                errors++;
                $display("FAIL bp_words got=%h %h %h %h %h required C0000000 0000000A 00400004 00000001 00000000",
                         got[0], got[1], got[2], got[3], got[4]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 12; i++)
            drive_cycle(1'b1, 1'b1, 32'h1000 + 32'(i * 4), 1'b1, 5'(i), 32'(i), 1'b0);
        checks++;
        if (drop_count !== 16'd4) begin
            errors++;
            $display("FAIL ovf_drops got=%0d required 4", drop_count);
        end
        collect(30);
        checks++;
        if (got.size() != 24) begin
            errors++;
            $display("FAIL ovf_count got=%0d words required 24", got.size());
        end else begin
            for (int r = 0; r < 8; r++) begin
                checks++;
                if (got[3*r] !== 32'h1000 + 32'(r * 4) || got[3*r+1][15:0] !== 16'(r)) begin
                    errors++;
                    $display("FAIL ovf_rec%0d pc=%h seq=%0d required %h/%0d",
                             r, got[3*r], got[3*r+1][15:0], 32'h1000 + 32'(r * 4), r);
                end
            end
        end
        drive_cycle(1'b1, 1'b1, 32'h2000, 1'b0, 5'd0, 32'h0, 1'b0);
        collect(4);
        checks++;
        if (got.size() != 3 || got[1] !== 32'h0000000C) begin
            errors++;
            $display("FAIL ovf_next_seq words=%0d word1=%h required 3/0000000C", got.size(),
                     got.size() > 1 ? got[1] : 32'hx);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            drive_cycle(1'b1, 1'b1, 32'h3000 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        checks++;
        if (out_last !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_w2 last=%b required 1", out_last);
        end
        drive_cycle(1'b1, 1'b1, 32'h3100, 1'b1, 5'd7, 32'h77, 1'b1);
        checks++;
        if (drop_count !== 16'd0) begin
            errors++;
            $display("FAIL fullpop_drops got=%0d required 0", drop_count);
        end
        collect(30);
        checks++;
        if (got.size() != 24 || got[21] !== 32'h3100 || got[22] !== 32'h9C000008 || got[23] !== 32'h77) begin
            errors++;
            $display("FAIL fullpop_drain words=%0d tail=%h required 24 words ending 3100 9C000008 00000077",
                     got.size(), got.size() > 0 ? got[got.size()-1] : 32'hx);
        end
    endtask

    task automatic test_reset_mid_record();
        do_reset();
        drive_cycle(1'b1, 1'b1, 32'h4000, 1'b0, 5'd0, 32'h0, 1'b1);
        idle(1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async valid=%b data=%h last=%b required 0/0/0", out_valid, out_data, out_last);
        end
        mq.delete(); m_idx = 0; m_seq = 0; m_drops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic cv, en, we, rdy;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cv  = ($urandom_range(0, 99) < 50);
            en  = ($urandom_range(0, 99) < 80);
            we  = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 99) < 65);
            drive_cycle(cv, en, $urandom, we, 5'($urandom_range(0, 31)), $urandom, rdy);
            checks++;
            if (out_valid !== exp_valid() || out_data !== exp_data() || out_last !== exp_last() ||
                drop_count !== 16'(m_drops)) begin
                errors++;
                $display("FAIL random cyc=%0d valid=%b data=%h last=%b drops=%0d required %b/%h/%b/%0d",
                         i, out_valid, out_data, out_last, drop_count,
                         exp_valid(), exp_data(), exp_last(), m_drops);
            end
        end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        for (int i = 0; i < 65535; i++)
            drive_cycle(1'b1, 1'b1, 32'(i), 1'b0, 5'd0, 32'h0, 1'b1);
        for (int i = 0; i < 30; i++) idle(1'b1);
        checks++;
        if (out_valid !== 1'b0 || drop_count !== 16'(m_drops) || m_seq != 65535) begin
            errors++;
            $display("FAIL wrap_preload valid=%b drops=%0d required 0/%0d", out_valid, drop_count, m_drops);
        end
        drive_cycle(1'b1, 1'b1, 32'hA0, 1'b0, 5'd0, 32'h0, 1'b0);
        drive_cycle(1'b1, 1'b1, 32'hA4, 1'b0, 5'd0, 32'h0, 1'b0);
        collect(8);
        checks++;
        if (got.size() != 6 || got[1] !== 32'h0000FFFF || got[4] !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap_seq words=%0d w1=%h w4=%h required 6/0000FFFF/00000000", got.size(),
                     got.size() > 1 ? got[1] : 32'hx, got.size() > 4 ? got[4] : 32'hx);
        end
        drive_cycle(1'b1, 1'b0, 32'hB0, 1'b1, 5'd3, 32'h5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL en_off cyc=%0d valid=%b required 0", i, out_valid);
            end
            idle(1'b0);
        end
        drive_cycle(1'b1, 1'b1, 32'hB4, 1'b0, 5'd0, 32'h0, 1'b0);
        collect(4);
        checks++;
        if (got.size() != 3 || got[1] !== 32'h00000001) begin
            errors++;
            $display("FAIL en_seq_frozen words=%0d w1=%h required 3/00000001", got.size(),
                     got.size() > 1 ? got[1] : 32'hx);
        end
    endtask

    initial begin
        test_reset();
        test_single_commit();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_reset_mid_record();
        test_random();
        test_seq_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
